// File: rtl/agent_link_pkg.sv
// Shared types and constants for the two-source agent link arbiter.
//   state_e     : arbiter FSM states
//   src_e       : beat source tag carried on the link
//   link_beat_t : payload held by the link output register
package agent_link_pkg;

  localparam int unsigned LINK_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

  typedef struct packed {
    logic [LINK_DATA_W-1:0] data;
    logic                   last;
    src_e                   src;
  } link_beat_t;

endpackage

// File: rtl/agent_link_if.sv
// Bundle of the two source request channels, the shared link and the grant.
//   master : arbiter side (accepts source beats, drives the link and grant)
//   slave  : environment side (agent sources and the receiving agent)
interface agent_link_if
  import agent_link_pkg::*;
#(
  parameter int unsigned DATA_W = LINK_DATA_W
) ();

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_last;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_last;
  logic              req1_ready;
  logic              link_valid;
  logic [DATA_W-1:0] link_data;
  logic              link_last;
  logic              link_src;
  logic              link_ready;
  logic [1:0]        grant;

  modport master (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  link_ready,
    output req0_ready, req1_ready,
    output link_valid, link_data, link_last, link_src,
    output grant
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output link_ready,
    input  req0_ready, req1_ready,
    input  link_valid, link_data, link_last, link_src,
    input  grant
  );

endinterface

// File: rtl/agent_link_oreg.sv
// Single-entry valid/ready output register for the link.
//   clk, reset_n : clock, async active-low reset (held beat is dropped)
//   i_load       : capture i_beat this cycle
//   i_beat       : beat payload {data, last, src}
//   i_ready      : downstream accepts the held beat
//   o_valid      : held beat is valid
//   o_beat       : held beat payload
//   o_space_c    : a new beat may be loaded this cycle (combinational)
module agent_link_oreg
  import agent_link_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  link_beat_t i_beat,
  input  logic       i_ready,
  output logic       o_valid,
  output link_beat_t o_beat,
  output logic       o_space_c
);

  logic       r_valid;
  link_beat_t r_beat;

  // Load wins over drain so a simultaneous drain+load keeps the link busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_beat    = r_beat;
  assign o_space_c = !r_valid || i_ready;

endmodule

// File: rtl/agent_link_arbiter.sv
// Round-robin burst arbiter sharing one link between agent source 0 and 1.
// A grant is held until the source sends a last beat or MAX_BURST beats.
//   clk, reset_n : clock, async active-low reset
//   link.req0_*  : agent 0 request channel (valid/data/last in, ready out)
//   link.req1_*  : agent 1 request channel (valid/data/last in, ready out)
//   link.link_*  : registered link beat with source tag, link_ready in
//   link.grant   : one-hot current grant, 2'b00 when idle
module agent_link_arbiter
  import agent_link_pkg::*;
#(
  parameter int unsigned DATA_W    = LINK_DATA_W,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input logic          clk,
  input logic          reset_n,
  agent_link_if.master link
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_last_winner;
  logic             w_last_winner_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic       w_space;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_acc;
  logic       w_acc_last;
  logic       w_cap;
  logic       w_release;
  link_beat_t w_beat_in;
  link_beat_t w_beat_out;
  logic       w_out_valid;

  // Ready is offered only to the granted source when the output stage has room.
  assign w_rdy0     = (r_state == GNT0) && w_space;
  assign w_rdy1     = (r_state == GNT1) && w_space;
  assign w_acc0     = link.req0_valid && w_rdy0;
  assign w_acc1     = link.req1_valid && w_rdy1;
  assign w_acc      = w_acc0 || w_acc1;
  assign w_acc_last = w_acc1 ? link.req1_last : link.req0_last;
  assign w_cap      = (r_cnt == CNT_W'(MAX_BURST - 1));
  assign w_release  = w_acc && (w_acc_last || w_cap);

  assign w_beat_in.data = w_acc1 ? LINK_DATA_W'(link.req1_data)
                                 : LINK_DATA_W'(link.req0_data);
  assign w_beat_in.last = w_acc_last;
  assign w_beat_in.src  = w_acc1 ? SRC1 : SRC0;

  agent_link_oreg u_oreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_acc),
    .i_beat    (w_beat_in),
    .i_ready   (link.link_ready),
    .o_valid   (w_out_valid),
    .o_beat    (w_beat_out),
    .o_space_c (w_space)
  );

  // State, round-robin pointer and burst counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_last_winner <= 1'b1;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_winner <= w_last_winner_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, hand over directly on release if the other side waits.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_winner_nxt = r_last_winner;
    w_cnt_nxt         = r_cnt;
    if (w_acc) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    unique case (r_state)
      IDLE: begin
        if (link.req0_valid && link.req1_valid) begin
          w_state_nxt = r_last_winner ? GNT0 : GNT1;
        end else if (link.req0_valid) begin
          w_state_nxt = GNT0;
        end else if (link.req1_valid) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (w_release) begin
          w_state_nxt = link.req1_valid ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (w_release) begin
          w_state_nxt = link.req0_valid ? GNT0 : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // A fresh grant starts a new burst count and becomes the last winner.
    if ((w_state_nxt != r_state) && (w_state_nxt != IDLE)) begin
      w_last_winner_nxt = (w_state_nxt == GNT1);
      w_cnt_nxt         = '0;
    end
  end

  assign link.req0_ready = w_rdy0;
  assign link.req1_ready = w_rdy1;
  assign link.link_valid = w_out_valid;
  assign link.link_data  = DATA_W'(w_beat_out.data);
  assign link.link_last  = w_beat_out.last;
  assign link.link_src   = w_beat_out.src;
  assign link.grant      = {r_state == GNT1, r_state == GNT0};

endmodule

// File: tb/tb_agent_link_arbiter.sv
// Scoreboard bench for agent_link_arbiter (MAX_BURST = 4).
module tb_agent_link_arbiter;

  localparam int unsigned MAXB = 4;

  typedef struct {
    logic       src;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } ent_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  agent_link_if bus ();

  agent_link_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .link    (bus)
  );

  int    total = 0;
  int    bad   = 0;
  ent_t  sb[$];
  ent_t  lg[$];
  int    gtr[$];
  beat_t q0[$];
  beat_t q1[$];
  int    mcyc = 0;
  int    e_first0;
  int    e_first1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       m_prev_rel = 1'b1;
  logic       m_prev_src = 1'b0;
  int         m_run = 0;
  logic       m_rr_pend = 1'b0;
  logic       m_rr_src = 1'b0;
  logic       m_stall = 1'b0;
  logic [9:0] m_shold = '0;
  int         g_prev = 0;
  ent_t       m_e;

  // Burst rules from the source point of view, then queue the expected link beat.
  task automatic mon_accept(input logic s, input logic [7:0] d, input logic l, input logic other_v);
    ent_t e;
    if (!m_prev_rel) chk("burst_hold_src", 32'(s), 32'(m_prev_src));
    else if (m_rr_pend) chk("rr_switch_src", 32'(s), 32'(m_rr_src));
    m_run      = (!m_prev_rel) ? m_run + 1 : 1;
    m_prev_rel = l || (m_run == int'(MAXB));
    m_rr_pend  = m_prev_rel && other_v;
    m_rr_src   = !s;
    m_prev_src = s;
    e.src = s; e.data = d; e.last = l; e.cyc = 0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    mcyc++;
    if (!reset_n) begin
      sb.delete();
      m_prev_rel = 1'b1;
      m_run      = 0;
      m_rr_pend  = 1'b0;
      m_stall    = 1'b0;
    end else begin
      if (m_stall) begin
        chk("stall_valid", 32'(bus.link_valid), 32'd1);
        chk("stall_payload", 32'({bus.link_src, bus.link_last, bus.link_data}), 32'(m_shold));
      end
      m_stall = bus.link_valid && !bus.link_ready;
      m_shold = {bus.link_src, bus.link_last, bus.link_data};
      if (bus.req0_ready || bus.req1_ready)
        chk("ready_onehot", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
      if (bus.link_valid && bus.link_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_link_beat", 32'd1, 32'd0);
        end else begin
          m_e = sb.pop_front();
          chk("link_beat", 32'({bus.link_src, bus.link_last, bus.link_data}),
              32'({m_e.src, m_e.last, m_e.data}));
        end
        m_e.src = bus.link_src; m_e.data = bus.link_data; m_e.last = bus.link_last; m_e.cyc = mcyc;
        lg.push_back(m_e);
      end
      if (bus.req0_valid && bus.req0_ready)
        mon_accept(1'b0, bus.req0_data, bus.req0_last, bus.req1_valid);
      if (bus.req1_valid && bus.req1_ready)
        mon_accept(1'b1, bus.req1_data, bus.req1_last, bus.req0_valid);
    end
    if (int'(bus.grant) != g_prev) gtr.push_back(int'(bus.grant));
    g_prev = int'(bus.grant);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.link_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One IDLE cycle with a valid from source s: ready must not appear yet.
  task automatic pre_cycle(input int s, input logic [7:0] d, input logic l);
    if (s == 0) begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_last = l;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_last = l;
    end
    @(negedge clk);
    chk("arb_latency_ready", 32'((s == 0) ? bus.req0_ready : bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Drains q0/q1 into the DUT and waits until the scoreboard is empty.
  task automatic run_engine(input int gap_pct, input int bp_pct, input int budget);
    int  cyc;
    logic a0, a1;
    cyc = 0;
    e_first0 = -1;
    e_first1 = -1;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && cyc < budget) begin
      if (q0.size() > 0) begin
        bus.req0_valid = ($urandom_range(99) >= gap_pct);
        bus.req0_data  = q0[0].data;
        bus.req0_last  = q0[0].last;
      end else bus.req0_valid = 1'b0;
      if (q1.size() > 0) begin
        bus.req1_valid = ($urandom_range(99) >= gap_pct);
        bus.req1_data  = q1[0].data;
        bus.req1_last  = q1[0].last;
      end else bus.req1_valid = 1'b0;
      bus.link_ready = ($urandom_range(99) >= bp_pct);
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (a0) begin void'(q0.pop_front()); if (e_first0 < 0) e_first0 = cyc; end
      if (a1) begin void'(q1.pop_front()); if (e_first1 < 0) e_first1 = cyc; end
      cyc++;
    end
    if (cyc >= budget) chk("engine_timeout", 32'd1, 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.link_ready = 1'b1;
  endtask

  task automatic push_beat(input int s, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    if (s == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  // ---------------- main sequence ----------------
  bit         t_v[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
  logic [7:0] t_d[8]  = '{8'h50, 8'h50, 8'h55, 8'h55, 8'h55, 8'h55, 8'h5A, 8'h00};
  bit         t_l[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  bit         t_r[8]  = '{1, 1, 0, 0, 0, 1, 1, 1};

  initial begin
    int n;
    logic [7:0] d;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
    bus.link_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_link_valid", 32'(bus.link_valid), 32'd0);
    chk("rst_link_data", 32'(bus.link_data), 32'd0);
    chk("rst_link_last", 32'(bus.link_last), 32'd0);
    chk("rst_link_src", 32'(bus.link_src), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    do_reset();

    // Single-source burst
    lg.delete();
    push_beat(0, 8'h11, 1'b0); push_beat(0, 8'h22, 1'b0); push_beat(0, 8'h33, 1'b1);
    pre_cycle(0, 8'h11, 1'b0);
    run_engine(0, 0, 200);
    idle(2);
    chk("t1_first_accept_cycle", 32'(e_first0), 32'd0);
    chk("t1_beats", 32'(lg.size()), 32'd3);
    if (lg.size() == 3) begin
      chk("t1_b0", 32'({lg[0].src, lg[0].last, lg[0].data}), 32'({1'b0, 1'b0, 8'h11}));
      chk("t1_b1", 32'({lg[1].src, lg[1].last, lg[1].data}), 32'({1'b0, 1'b0, 8'h22}));
      chk("t1_b2", 32'({lg[2].src, lg[2].last, lg[2].data}), 32'({1'b0, 1'b1, 8'h33}));
      chk("t1_b2_back_to_back", 32'(lg[2].cyc - lg[0].cyc), 32'd2);
    end
    chk("t1_grant_idle", 32'(bus.grant), 32'd0);

    // Simultaneous requests after reset
    do_reset();
    lg.delete(); gtr.delete();
    push_beat(0, 8'hA0, 1'b1); push_beat(1, 8'hB0, 1'b1);
    run_engine(0, 0, 200);
    idle(2);
    chk("t2_beats", 32'(lg.size()), 32'd2);
    if (lg.size() == 2) begin
      chk("t2_first", 32'({lg[0].src, lg[0].data}), 32'({1'b0, 8'hA0}));
      chk("t2_second", 32'({lg[1].src, lg[1].data}), 32'({1'b1, 8'hB0}));
      chk("t2_no_bubble", 32'(lg[1].cyc - lg[0].cyc), 32'd1);
    end
    chk("t2_grant_changes", 32'(gtr.size()), 32'd3);
    if (gtr.size() == 3) begin
      chk("t2_grant0", 32'(gtr[0]), 32'd1);
      chk("t2_grant1", 32'(gtr[1]), 32'd2);
      chk("t2_grant2", 32'(gtr[2]), 32'd0);
    end

    // Round robin with single-beat bursts
    lg.delete();
    for (int i = 0; i < 3; i++) begin
      push_beat(0, 8'(8'h20 + i), 1'b1);
      push_beat(1, 8'(8'h30 + i), 1'b1);
    end
    run_engine(0, 0, 200);
    idle(2);
    chk("t3_beats", 32'(lg.size()), 32'd6);
    for (int i = 0; i < 6 && i < lg.size(); i++)
      chk("t3_alternate_src", 32'(lg[i].src), 32'(i % 2));

    // Forced release at MAX_BURST
    lg.delete();
    for (int i = 0; i < 20; i++) push_beat(1, 8'(i), 1'b0);
    pre_cycle(1, 8'h00, 1'b0);
    push_beat(0, 8'hC5, 1'b1);
    run_engine(0, 0, 400);
    idle(2);
    chk("t4_beats", 32'(lg.size()), 32'd21);
    if (lg.size() == 21) begin
      n = 0;
      for (int i = 0; i < 21; i++) begin
        if (i == 4) begin
          chk("t4_switch_beat", 32'({lg[i].src, lg[i].last, lg[i].data}), 32'({1'b0, 1'b1, 8'hC5}));
        end else begin
          d = 8'(n);
          chk("t4_src1_beat", 32'({lg[i].src, lg[i].last, lg[i].data}), 32'({1'b1, 1'b0, d}));
          n++;
        end
      end
    end

    // Backpressure mid-burst
    lg.delete();
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = t_v[i];
      bus.req0_data  = t_d[i];
      bus.req0_last  = t_l[i];
      bus.link_ready = t_r[i];
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        chk("t5_ready0_low", 32'(bus.req0_ready), 32'd0);
        chk("t5_hold_data", 32'(bus.link_data), 32'h50);
      end
      @(posedge clk);
      #1;
    end
    idle(2);
    chk("t5_beats", 32'(lg.size()), 32'd3);
    if (lg.size() == 3) begin
      chk("t5_b0", 32'(lg[0].data), 32'h50);
      chk("t5_b1_once", 32'(lg[1].data), 32'h55);
      chk("t5_b2", 32'({lg[2].last, lg[2].data}), 32'({1'b1, 8'h5A}));
    end

    // Reset during the second beat of a source 1 burst
    bus.req1_valid = 1'b1; bus.req1_data = 8'h61; bus.req1_last = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    bus.req1_data = 8'h62;
    @(negedge clk);
    #2 reset_n = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("t6_link_valid_async", 32'(bus.link_valid), 32'd0);
    chk("t6_grant_async", 32'(bus.grant), 32'd0);
    chk("t6_ready1_async", 32'(bus.req1_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    lg.delete();
    push_beat(0, 8'h70, 1'b1); push_beat(1, 8'h71, 1'b1);
    run_engine(0, 0, 200);
    idle(2);
    chk("t6_beats", 32'(lg.size()), 32'd2);
    if (lg.size() == 2) begin
      chk("t6_src0_first", 32'({lg[0].src, lg[0].data}), 32'({1'b0, 8'h70}));
      chk("t6_src1_second", 32'({lg[1].src, lg[1].data}), 32'({1'b1, 8'h71}));
    end

    // Random bursts, gaps and backpressure
    for (int s = 0; s < 2; s++) begin
      n = 0;
      while (n < 150) begin
        int len;
        len = int'($urandom_range(6, 1));
        for (int k = 0; k < len; k++) begin
          push_beat(s, 8'($urandom), (k == len - 1));
          n++;
        end
      end
    end
    run_engine(30, 30, 20000);
    idle(4);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_grant_idle", 32'(bus.grant), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
